// File: rtl/bcd_convert_seq_ctrl.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// One binary bit is consumed per clock, so a single per-nibble add-3 stage
// is reused for every iteration. Valid/ready handshakes on input and output.
module bcd_convert_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_bin;
  logic [SW-1:0]     r_scr;
  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_bcd;

  logic [SW-1:0]       w_adj;
  logic [SW+WIDTH-1:0] w_shift;
  logic                w_accept;
  logic                w_last;

  // Add 3 to every scratch digit that is 5 or more; nibbles never carry
  // into each other because a digit is at most 9 before the add.
  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Iteration datapath: correct digits, then shift {scratch, binary} left.
  always_comb begin
    w_adj    = add3(r_scr);
    w_shift  = {w_adj, r_bin} << 1;
    w_accept = in_valid && (r_state == S_IDLE);
    w_last   = (r_cnt == CW'(1));
  end

  // Control FSM plus shift/scratch/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bin   <= in_data;
            r_scr   <= '0;
            r_cnt   <= CW'(WIDTH);
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scr <= w_shift[SW+WIDTH-1:WIDTH];
          r_bin <= w_shift[WIDTH-1:0];
          r_cnt <= r_cnt - CW'(1);
          // The final iteration's shifted scratch is the finished result,
          // so it is captured into bcd on the same edge that enters DONE.
          if (w_last) begin
            r_bcd   <= w_shift[SW+WIDTH-1:WIDTH];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state == S_SHIFT);
    out_valid = (r_state == S_DONE);
    bcd       = r_bcd;
  end

endmodule

// File: tb/tb_bcd_convert_seq_ctrl.sv
// Self-checking bench for bcd_convert_seq_ctrl: directed cases, reset abort,
// held-valid during conversion, random holds and an exhaustive sweep.
module tb_bcd_convert_seq_ctrl;

  localparam int  WIDTH  = 8;
  localparam int  DIGITS = 4;
  localparam int  SW     = 4 * DIGITS;
  localparam time TCLK   = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [SW-1:0]    bcd;
  logic             busy;

  int  n_chk = 0;
  int  n_fail = 0;
  time t_last_acc = 0;
  bit  ii_check = 1'b0;

  bcd_convert_seq_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .busy      (busy)
  );

  always #(TCLK/2) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by repeated divide/mod, packed LSD in the low nibble.
  function automatic int ref_bcd(input int v);
    int x, res;
    x = v;
    res = 0;
    for (int d = 0; d < DIGITS; d++) begin
      res = res | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return res;
  endfunction

  // One full transaction. hold = cycles with out_ready low in DONE;
  // keep = leave in_valid high with other data while the conversion runs.
  task automatic conv(input int v, input int hold, input bit keep);
    int guard;
    int lat;
    @(negedge clk);
    in_data   = v[WIDTH-1:0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (ii_check) chk("interval", int'(($time - t_last_acc) / TCLK), WIDTH + 2);
    t_last_acc = $time;
    #1;
    if (keep) in_data = v[WIDTH-1:0] ^ 8'h5A;
    else begin
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
    end
    chk("busy_after_accept", busy, 1);
    chk("in_ready_in_shift", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (keep) in_data = WIDTH'($urandom);
    end
    // Counting the accepting edge itself, out_valid is up after WIDTH+1 edges.
    chk("latency", lat, WIDTH);
    chk("bcd", bcd, ref_bcd(v));
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_bcd", bcd, ref_bcd(v));
        chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #(200us);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_valid;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bcd", bcd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values including both range ends
    conv(0, 0, 0);
    conv(255, 0, 0);
    conv(99, 0, 0);
    conv(100, 0, 0);

    // Consumer stall for 20 cycles
    conv(137, 20, 0);

    // Reset during the fourth iteration of a conversion of 200
    @(negedge clk);
    in_data  = 8'd200;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_bcd", bcd, 0);
    seen_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_valid", seen_valid, 0);
    chk("abort_idle_ready", in_ready, 1);
    conv(45, 0, 0);

    // in_valid kept high with other data while converting
    conv(23, 0, 1);
    conv(178, 0, 1);
    conv(61, 0, 0);

    // Random values with random consumer stalls
    for (int k = 0; k < 20; k++) begin
      conv(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Exhaustive back-to-back sweep with interval checking
    ii_check = 1'b0;
    for (int v = 0; v < 256; v++) begin
      conv(v, 0, 0);
      ii_check = 1'b1;
    end
    ii_check = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
